mips_decode_nextpc: RTL and testbench



---
 rtl/mips_decode_nextpc.sv | 163 ++++++++++++++++
 tb/tb_mips_decode_nextpc.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_nextpc.sv
// Single-cycle MIPS decode and next-PC block: turns the instruction into datapath
// controls and an ALU op, and holds the 13-bit word-addressed program counter.
module mips_decode_nextpc (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero_flag,
    input  logic [12:0] rs_data,
    output logic [12:0] pc,
    output logic [12:0] pc_plus1,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        zero_ext,
    output logic        beq,
    output logic        bne,
    output logic        jump,
    output logic        jr,
    output logic        jal,
    output logic        reg_write,
    output logic [4:0]  write_reg
);

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write_raw;
    logic [12:0] pc_q;
    logic [12:0] pc_d;
    logic [12:0] branch_target;
    logic        branch_taken;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    // rs is read by the register file directly; this block never looks at it
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        alu_control   = AluAdd;
        alu_src       = 1'b0;
        reg_dst       = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        mem_to_reg    = 1'b0;
        zero_ext      = 1'b0;
        beq           = 1'b0;
        bne           = 1'b0;
        jump          = 1'b0;
        jr            = 1'b0;
        jal           = 1'b0;
        reg_write_raw = 1'b0;
        case (opcode)
            6'b000000: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
                case (funct)
                    6'b100000: alu_control = AluAdd;
                    6'b100010: alu_control = AluSub;
                    6'b100100: alu_control = AluAnd;
                    6'b100101: alu_control = AluOr;
                    6'b100111: alu_control = AluNor;
                    6'b101010: alu_control = AluSlt;
                    6'b000000: alu_control = AluSll;
                    6'b000010: alu_control = AluSrl;
                    6'b001000: jr = 1'b1;
                    default:   reg_write_raw = 1'b0;
                endcase
            end
            6'b001000: begin
                alu_src       = 1'b1;
                reg_write_raw = 1'b1;
            end
            6'b001010: begin
                alu_src       = 1'b1;
                reg_write_raw = 1'b1;
                alu_control   = AluSlt;
            end
            6'b001100: begin
                alu_src       = 1'b1;
                reg_write_raw = 1'b1;
                zero_ext      = 1'b1;
                alu_control   = AluAnd;
            end
            6'b001101: begin
                alu_src       = 1'b1;
                reg_write_raw = 1'b1;
                zero_ext      = 1'b1;
                alu_control   = AluOr;
            end
            6'b100011: begin
                alu_src       = 1'b1;
                mem_read      = 1'b1;
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            6'b101011: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            6'b000100: begin
                beq         = 1'b1;
                alu_control = AluSub;
            end
            6'b000101: begin
                bne         = 1'b1;
                alu_control = AluSub;
            end
            6'b000010: jump = 1'b1;
            6'b000011: begin
                jump          = 1'b1;
                jal           = 1'b1;
                reg_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    assign reg_write = reg_write_raw & ~jr;
    assign write_reg = jal ? 5'd31 : (reg_dst ? rd : rt);

    assign pc_plus1      = pc_q + 13'd1;
    assign branch_target = pc_plus1 + instr[12:0];
    assign branch_taken  = (beq & zero_flag) | (bne & ~zero_flag);

    // Priority only matters for malformed combinations; decode keeps these exclusive
    always_comb begin
        if (jr)
            pc_d = rs_data;
        else if (jump)
            pc_d = instr[12:0];
        else if (branch_taken)
            pc_d = branch_target;
        else
            pc_d = pc_plus1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= 13'd0;
        else
            pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_mips_decode_nextpc.sv
// Self-checking bench for mips_decode_nextpc: directed scenarios plus random
// instructions compared against a behavioural ISA-level model.
module tb_mips_decode_nextpc;

    typedef struct packed {
        logic [3:0] alu;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       zero_ext;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       jr;
        logic       jal;
        logic       reg_write;
        logic [4:0] write_reg;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero_flag;
    logic [12:0] rs_data;
    logic [12:0] pc;
    logic [12:0] pc_plus1;
    logic [3:0]  alu_control;
    logic        alu_src, reg_dst, mem_write, mem_read, mem_to_reg, zero_ext;
    logic        beq, bne, jump, jr, jal, reg_write;
    logic [4:0]  write_reg;

    int checks;
    int failures;
    int exp_pc;

    mips_decode_nextpc dut (
        .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag),
        .rs_data(rs_data), .pc(pc), .pc_plus1(pc_plus1),
        .alu_control(alu_control), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_write(mem_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .zero_ext(zero_ext), .beq(beq), .bne(bne), .jump(jump), .jr(jr),
        .jal(jal), .reg_write(reg_write), .write_reg(write_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode, table-driven from the instruction set description
    function automatic ctrl_t ref_decode(input logic [31:0] ins);
        ctrl_t c;
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        c = '0;
        c.alu = 4'b0010;
        if (op == 0) begin
            c.reg_dst = 1'b1;
            c.reg_write = 1'b1;
            case (fn)
                32: c.alu = 4'b0010;
                34: c.alu = 4'b0110;
                36: c.alu = 4'b0000;
                37: c.alu = 4'b0001;
                39: c.alu = 4'b1100;
                42: c.alu = 4'b0111;
                0:  c.alu = 4'b1000;
                2:  c.alu = 4'b1001;
                8:  begin c.jr = 1'b1; c.reg_write = 1'b0; end
                default: c.reg_write = 1'b0;
            endcase
        end
        else if (op == 8)  begin c.alu_src = 1; c.reg_write = 1; end
        else if (op == 10) begin c.alu_src = 1; c.reg_write = 1; c.alu = 4'b0111; end
        else if (op == 12) begin c.alu_src = 1; c.reg_write = 1; c.zero_ext = 1; c.alu = 4'b0000; end
        else if (op == 13) begin c.alu_src = 1; c.reg_write = 1; c.zero_ext = 1; c.alu = 4'b0001; end
        else if (op == 35) begin c.alu_src = 1; c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; end
        else if (op == 43) begin c.alu_src = 1; c.mem_write = 1; end
        else if (op == 4)  begin c.beq = 1; c.alu = 4'b0110; end
        else if (op == 5)  begin c.bne = 1; c.alu = 4'b0110; end
        else if (op == 2)  c.jump = 1;
        else if (op == 3)  begin c.jump = 1; c.jal = 1; c.reg_write = 1; end
        if (c.jal)
            c.write_reg = 5'd31;
        else if (c.reg_dst)
            c.write_reg = ins[15:11];
        else
            c.write_reg = ins[20:16];
        return c;
    endfunction

    // Reference next PC using integer arithmetic modulo the 8192-word space
    function automatic int ref_next(input int cur, input logic [31:0] ins,
                                    input logic zf, input logic [12:0] rs);
        ctrl_t c;
        int off;
        c = ref_decode(ins);
        off = int'(ins[12:0]);
        if (off >= 4096)
            off = off - 8192;
        if (c.jr)
            return int'(rs);
        if (c.jump)
            return int'(ins[12:0]);
        if ((c.beq && zf) || (c.bne && !zf))
            return ((cur + 1 + off) % 8192 + 8192) % 8192;
        return (cur + 1) % 8192;
    endfunction

    function automatic ctrl_t observed();
        ctrl_t c;
        c.alu = alu_control; c.alu_src = alu_src; c.reg_dst = reg_dst;
        c.mem_write = mem_write; c.mem_read = mem_read; c.mem_to_reg = mem_to_reg;
        c.zero_ext = zero_ext; c.beq = beq; c.bne = bne; c.jump = jump;
        c.jr = jr; c.jal = jal; c.reg_write = reg_write; c.write_reg = write_reg;
        return c;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic zf, input logic [12:0] rs);
        instr = ins;
        zero_flag = zf;
        rs_data = rs;
        #1;
    endtask

    task automatic step();
        exp_pc = ref_next(exp_pc, instr, zero_flag, rs_data);
        @(posedge clk);
        #2;
    endtask

    task automatic goto_pc(input int target);
        drive({6'b000010, 13'd0, 13'(target)}, 1'b0, 13'd0);
        step();
        if (pc !== 13'(target)) begin
            failures++;
            $display("[TB] FAIL goto_pc: pc=%0h expected %0h", pc, target);
        end
        checks++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'd0, 1'b0, 13'd0);
        @(posedge clk);
        #2;
        checks++;
        if (pc !== 13'd0 || pc_plus1 !== 13'd1) begin
            failures++;
            $display("[TB] FAIL reset_hold: pc=%0h pc_plus1=%0h expected 0/1", pc, pc_plus1);
        end
        reset = 1'b0;
        exp_pc = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pc !== 13'(i)) begin
                failures++;
                $display("[TB] FAIL nop_seq: pc=%0h expected %0h", pc, i);
            end
        end
        // Async reset between edges must clear pc without a clock
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pc !== 13'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: pc=%0h expected 0", pc);
        end
        #2;
        reset = 1'b0;
        exp_pc = 0;
        drive({6'b000010, 13'd0, 13'h055}, 1'b0, 13'd0);
        step();
        checks++;
        if (pc !== 13'h055) begin
            failures++;
            $display("[TB] FAIL post_reset_jump: pc=%0h expected 55", pc);
        end
    endtask

    task automatic test_rtype_itype();
        ctrl_t o;
        drive(32'h00221820, 1'b0, 13'd0);
        o = observed();
        checks++;
        if (o.reg_dst !== 1'b1 || o.reg_write !== 1'b1 || o.alu !== 4'b0010 || o.write_reg !== 5'd3) begin
            failures++;
            $display("[TB] FAIL add_decode: got %h", o);
        end
        drive(32'h34220005, 1'b0, 13'd0);
        o = observed();
        checks++;
        if (o.alu_src !== 1'b1 || o.zero_ext !== 1'b1 || o.alu !== 4'b0001 || o.write_reg !== 5'd2) begin
            failures++;
            $display("[TB] FAIL ori_decode: got %h", o);
        end
    endtask

    task automatic test_branch();
        goto_pc(10);
        drive({6'b000100, 5'd1, 5'd2, 16'd5}, 1'b1, 13'd0);
        step();
        checks++;
        if (pc !== 13'd16) begin
            failures++;
            $display("[TB] FAIL beq_taken: pc=%0d expected 16", pc);
        end
        goto_pc(10);
        drive({6'b000100, 5'd1, 5'd2, 16'd5}, 1'b0, 13'd0);
        step();
        checks++;
        if (pc !== 13'd11) begin
            failures++;
            $display("[TB] FAIL beq_not_taken: pc=%0d expected 11", pc);
        end
        goto_pc(10);
        drive({6'b000101, 5'd1, 5'd2, 16'h1FFE}, 1'b0, 13'd0);
        step();
        checks++;
        if (pc !== 13'd9) begin
            failures++;
            $display("[TB] FAIL bne_backward: pc=%0d expected 9", pc);
        end
    endtask

    task automatic test_jump();
        drive({6'b000010, 13'd0, 13'h100}, 1'b0, 13'd0);
        step();
        checks++;
        if (pc !== 13'h100) begin
            failures++;
            $display("[TB] FAIL j_target: pc=%0h expected 100", pc);
        end
        goto_pc(20);
        drive({6'b000011, 13'd0, 13'h040}, 1'b0, 13'd0);
        checks++;
        if (pc_plus1 !== 13'd21 || write_reg !== 5'd31 || reg_write !== 1'b1 || jal !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jal_link: pc_plus1=%0d write_reg=%0d reg_write=%b jal=%b expected 21/31/1/1",
                     pc_plus1, write_reg, reg_write, jal);
        end
        step();
        drive({6'b000000, 5'd4, 15'd0, 6'b001000}, 1'b0, 13'h0AB);
        checks++;
        if (reg_write !== 1'b0 || jr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jr_decode: reg_write=%b jr=%b expected 0/1", reg_write, jr);
        end
        step();
        checks++;
        if (pc !== 13'h0AB) begin
            failures++;
            $display("[TB] FAIL jr_target: pc=%0h expected ab", pc);
        end
    endtask

    task automatic test_mem();
        drive({6'b100011, 5'd1, 5'd7, 16'd4}, 1'b0, 13'd0);
        checks++;
        if (mem_read !== 1'b1 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 || alu_control !== 4'b0010 || write_reg !== 5'd7) begin
            failures++;
            $display("[TB] FAIL lw_decode: got %h", observed());
        end
        drive({6'b101011, 5'd1, 5'd7, 16'd4}, 1'b0, 13'd0);
        checks++;
        if (mem_write !== 1'b1 || reg_write !== 1'b0 || mem_read !== 1'b0 || alu_src !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sw_decode: got %h", observed());
        end
    endtask

    task automatic test_boundary();
        ctrl_t o;
        goto_pc(13'h1FFF);
        drive(32'd0, 1'b0, 13'd0);
        step();
        checks++;
        if (pc !== 13'd0) begin
            failures++;
            $display("[TB] FAIL pc_wrap: pc=%0h expected 0", pc);
        end
        goto_pc(13'h1FFE);
        drive({6'b000100, 5'd0, 5'd0, 16'd4}, 1'b1, 13'd0);
        step();
        checks++;
        if (pc !== 13'd3) begin
            failures++;
            $display("[TB] FAIL branch_wrap: pc=%0h expected 3", pc);
        end
        drive({6'b111111, 5'd3, 5'd9, 16'hFFFF}, 1'b1, 13'h1234);
        o = observed();
        checks++;
        if (o !== {4'b0010, 12'd0, 5'd9}) begin
            failures++;
            $display("[TB] FAIL unknown_opcode: got %h expected %h", o, {4'b0010, 12'd0, 5'd9});
        end
        step();
        checks++;
        if (pc !== 13'd4) begin
            failures++;
            $display("[TB] FAIL unknown_next: pc=%0h expected 4", pc);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [0:11];
        logic [5:0] fns [0:10];
        logic [31:0] ins;
        ctrl_t exp_c;
        ctrl_t o;
        ops = '{6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd63};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2, 6'd8, 6'd1, 6'd63};
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 11)];
            if (ins[31:26] == 6'd0)
                ins[5:0] = fns[$urandom_range(0, 10)];
            drive(ins, 1'($urandom), 13'($urandom));
            exp_c = ref_decode(ins);
            o = observed();
            checks++;
            if (o !== exp_c) begin
                failures++;
                $display("[TB] FAIL rand_decode: instr=%h got %h expected %h", ins, o, exp_c);
            end
            checks++;
            if (pc_plus1 !== 13'((exp_pc + 1) % 8192)) begin
                failures++;
                $display("[TB] FAIL rand_pc_plus1: got %0h expected %0h", pc_plus1, (exp_pc + 1) % 8192);
            end
            step();
            checks++;
            if (pc !== 13'(exp_pc)) begin
                failures++;
                $display("[TB] FAIL rand_next_pc: instr=%h got %0h expected %0h", ins, pc, exp_pc);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_pc = 0;
        reset = 1'b1;
        instr = 32'd0;
        zero_flag = 1'b0;
        rs_data = 13'd0;
        #3;
        test_reset();
        test_rtype_itype();
        test_branch();
        test_jump();
        test_mem();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
